// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-word stall buffer and redirect kill.
// Optional IF_TRACKER_EN enables the per-delivery sequence tag counter; otherwise IF_tracker_o is 8'h00.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall_if,
  input  logic        Inst_jump_i,
  input  logic [31:0] Src_jump_target_i,
  input  logic        Branch_taken_i,
  input  logic [31:0] Src_branch_target_i,
  output logic        Imem_req_o,
  output logic [31:0] Imem_addr_o,
  input  logic        Imem_valid_i,
  input  logic [31:0] Imem_rdata_i,
  output logic [31:0] Instruction_o,
  output logic [31:0] Src_pc_o,
  output logic [7:0]  IF_tracker_o
);

  // state | meaning
  // IDLE  | post-reset settle cycle, memory responses ignored
  // REQ   | issue one request at pc
  // WAIT  | request outstanding, waiting for Imem_valid_i
  // HOLD  | response parked in hold buffer while downstream stalls
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] src_pc_q, src_pc_d;
  logic [31:0] hold_q, hold_d;
  logic        kill_q, kill_d;
  logic        deliver;
  logic [31:0] deliver_word;
  logic        redirect;
  logic [31:0] redirect_sel;

  assign redirect     = Branch_taken_i | Inst_jump_i;
  assign redirect_sel = Branch_taken_i ? Src_branch_target_i : Src_jump_target_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    src_pc_d     = src_pc_q;
    hold_d       = hold_q;
    kill_d       = kill_q;
    inst_d       = Stall_if ? inst_q : NOP_INST;
    deliver      = 1'b0;
    deliver_word = Imem_rdata_i;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        if (redirect) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (Imem_valid_i) begin
          // A killed or redirect-coincident response is dropped without delivery.
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (Stall_if) begin
            hold_d  = Imem_rdata_i;
            state_d = S_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = S_REQ;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!Stall_if) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      inst_d   = deliver_word;
      src_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end
    if (redirect) begin
      pc_d   = {redirect_sel[31:2], 2'b00};
      inst_d = NOP_INST;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      src_pc_q <= 32'h0;
      hold_q   <= 32'h0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      src_pc_q <= src_pc_d;
      hold_q   <= hold_d;
      kill_q   <= kill_d;
    end
  end

`ifdef IF_TRACKER_EN
  logic [7:0] tag_q;

  always_ff @(posedge Clk) begin
    if (Reset) tag_q <= 8'h00;
    else if (deliver) tag_q <= tag_q + 8'd1;
  end

  assign IF_tracker_o = tag_q;
`else
  assign IF_tracker_o = 8'h00;
`endif

  assign Imem_req_o    = (state_q == S_REQ);
  assign Imem_addr_o   = pc_q;
  assign Instruction_o = inst_q;
  assign Src_pc_o      = src_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: bench-side memory, program-order fetch model checked every cycle, directed scenarios.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_TRACKER_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall_if = 1'b0;
  logic        Inst_jump_i = 1'b0;
  logic [31:0] Src_jump_target_i = 32'h0;
  logic        Branch_taken_i = 1'b0;
  logic [31:0] Src_branch_target_i = 32'h0;
  logic        Imem_valid_i = 1'b0;
  logic [31:0] Imem_rdata_i = 32'h0;
  logic        Imem_req_o, Imem_req_o2;
  logic [31:0] Imem_addr_o, Imem_addr_o2;
  logic [31:0] Instruction_o, Instruction_o2;
  logic [31:0] Src_pc_o, Src_pc_o2;
  logic [7:0]  IF_tracker_o, IF_tracker_o2;

  if_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall_if(Stall_if),
    .Inst_jump_i(Inst_jump_i), .Src_jump_target_i(Src_jump_target_i),
    .Branch_taken_i(Branch_taken_i), .Src_branch_target_i(Src_branch_target_i),
    .Imem_req_o(Imem_req_o), .Imem_addr_o(Imem_addr_o),
    .Imem_valid_i(Imem_valid_i), .Imem_rdata_i(Imem_rdata_i),
    .Instruction_o(Instruction_o), .Src_pc_o(Src_pc_o), .IF_tracker_o(IF_tracker_o)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .Stall_if(Stall_if),
    .Inst_jump_i(Inst_jump_i), .Src_jump_target_i(Src_jump_target_i),
    .Branch_taken_i(Branch_taken_i), .Src_branch_target_i(Src_branch_target_i),
    .Imem_req_o(Imem_req_o2), .Imem_addr_o(Imem_addr_o2),
    .Imem_valid_i(Imem_valid_i), .Imem_rdata_i(Imem_rdata_i),
    .Instruction_o(Instruction_o2), .Src_pc_o(Src_pc_o2), .IF_tracker_o(IF_tracker_o2)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [7:0] exp_tag(input int n);
    if (TR) return n[7:0];
    return 8'h00;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  // Memory: accepts every request, answers with one valid pulse mem_lat cycles later.
  int          mem_lat = 1;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  always @(negedge Clk) begin
    if (Imem_req_o === 1'b1) begin
      chk32("one_outstanding", {31'h0, mem_pend}, 32'h0);
      mem_pend = 1'b1;
      mem_addr = Imem_addr_o;
      mem_cnt  = mem_lat;
    end
  end

  always @(posedge Clk) begin
    #1;
    Imem_valid_i = 1'b0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        Imem_valid_i = 1'b1;
        Imem_rdata_i = mem_word(mem_addr);
        mem_pend     = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  logic [31:0] d2_addrs[$];
  always @(negedge Clk) begin
    if (Imem_req_o2 === 1'b1 && d2_addrs.size() < 2) d2_addrs.push_back(Imem_addr_o2);
  end

  // Inputs as seen by the most recent active edge.
  bit          have_edge = 1'b0;
  logic        e_rst, e_stall, e_br, e_jmp;
  logic [31:0] e_bt, e_jt;
  always @(posedge Clk) begin
    e_rst     = Reset;
    e_stall   = Stall_if;
    e_br      = Branch_taken_i;
    e_jmp     = Inst_jump_i;
    e_bt      = Src_branch_target_i;
    e_jt      = Src_jump_target_i;
    have_edge = 1'b1;
  end

  // Program-order model: words come out in pc order, redirects restart the order at the target.
  logic [31:0] m_pc = 32'h0;
  int          ndel = 0;
  logic [31:0] p_inst, p_src;
  logic [7:0]  p_tag;
  logic        p_req = 1'b0;

  always @(negedge Clk) begin
    if (have_edge) begin
      if (e_rst) begin
        m_pc = 32'h0;
        ndel = 0;
        chk32("rst_inst", Instruction_o, NOP);
        chk32("rst_src", Src_pc_o, 32'h0);
        chk32("rst_tag", {24'h0, IF_tracker_o}, 32'h0);
        chk32("rst_addr", Imem_addr_o, 32'h0);
      end else if (e_br || e_jmp) begin
        m_pc = e_br ? {e_bt[31:2], 2'b00} : {e_jt[31:2], 2'b00};
        chk32("redir_nop", Instruction_o, NOP);
        chk32("redir_src", Src_pc_o, p_src);
        chk32("redir_tag", {24'h0, IF_tracker_o}, {24'h0, p_tag});
      end else if (e_stall) begin
        chk32("stall_inst", Instruction_o, p_inst);
        chk32("stall_src", Src_pc_o, p_src);
        chk32("stall_tag", {24'h0, IF_tracker_o}, {24'h0, p_tag});
      end else if (Instruction_o !== NOP) begin
        ndel++;
        chk32("del_pc", Src_pc_o, m_pc);
        chk32("del_word", Instruction_o, mem_word(m_pc));
        chk32("del_tag", {24'h0, IF_tracker_o}, {24'h0, exp_tag(ndel)});
        m_pc = m_pc + 32'd4;
      end else begin
        chk32("bubble_src", Src_pc_o, p_src);
        chk32("bubble_tag", {24'h0, IF_tracker_o}, {24'h0, p_tag});
      end
      if (Imem_req_o === 1'b1) begin
        chk32("req_addr", Imem_addr_o, m_pc);
        chk32("req_single", {31'h0, p_req}, 32'h0);
      end
      p_inst = Instruction_o;
      p_src  = Src_pc_o;
      p_tag  = IF_tracker_o;
      p_req  = Imem_req_o;
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (Imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (Imem_req_o !== 1'b1) timeout(name);
  endtask

  task automatic wait_del(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (Instruction_o === NOP && n < 30);
    if (Instruction_o === NOP) timeout(name);
  endtask

  initial begin
    repeat (3) tick();
    Reset = 1'b0;

    // Words A,B at 0x0/0x4, first word three edges after release, NOP between.
    repeat (3) tick();
    chk32("first_word", Instruction_o, 32'hC0DE_0000);
    chk32("first_pc", Src_pc_o, 32'h0);
    chk32("first_tag", {24'h0, IF_tracker_o}, TR ? 32'h1 : 32'h0);
    tick();
    chk32("gap_nop", Instruction_o, NOP);
    tick();
    chk32("second_word", Instruction_o, 32'hC0DE_0004);
    chk32("second_pc", Src_pc_o, 32'h4);
    chk32("second_tag", {24'h0, IF_tracker_o}, TR ? 32'h2 : 32'h0);
    chk32("wrap_req_count", d2_addrs.size(), 32'd2);
    if (d2_addrs.size() == 2) begin
      chk32("wrap_first_addr", d2_addrs[0], 32'hFFFF_FFFC);
      chk32("wrap_second_addr", d2_addrs[1], 32'h0000_0000);
    end

    // Stall while word C returns: park in HOLD, no new request, deliver on release.
    wait_req("stall_req");
    chk32("stall_req_addr", Imem_addr_o, 32'h8);
    Stall_if = 1'b1;
    repeat (4) begin
      tick();
      chk32("stall_no_req", {31'h0, Imem_req_o}, 32'h0);
    end
    chk32("stall_held_word", Instruction_o, 32'hC0DE_0004);
    mem_lat  = 2;
    Stall_if = 1'b0;
    tick();
    chk32("hold_release_word", Instruction_o, 32'hC0DE_0008);
    chk32("hold_release_pc", Src_pc_o, 32'h8);

    // Jump to 0x103 while waiting: response killed, refetch at 0x100.
    wait_req("jump_req");
    chk32("jump_req_addr", Imem_addr_o, 32'hC);
    tick();
    Inst_jump_i = 1'b1;
    Src_jump_target_i = 32'h103;
    tick();
    Inst_jump_i = 1'b0;
    chk32("jump_flush_nop", Instruction_o, NOP);
    chk32("jump_kill_wait", {31'h0, Imem_req_o}, 32'h0);
    tick();
    chk32("jump_discard_nop", Instruction_o, NOP);
    chk32("jump_new_req", {31'h0, Imem_req_o}, 32'h1);
    chk32("jump_new_addr", Imem_addr_o, 32'h100);
    wait_del("jump_del");
    chk32("jump_del_word", Instruction_o, 32'hC0DE_0100);

    // Branch and jump together in REQ: branch wins.
    wait_req("bj_req");
    Branch_taken_i = 1'b1;
    Src_branch_target_i = 32'h200;
    Inst_jump_i = 1'b1;
    Src_jump_target_i = 32'h300;
    tick();
    Branch_taken_i = 1'b0;
    Inst_jump_i = 1'b0;
    wait_req("bj_new_req");
    chk32("bj_addr", Imem_addr_o, 32'h200);
    wait_del("bj_del");
    chk32("bj_del_word", Instruction_o, 32'hC0DE_0200);

    // Redirect coinciding with valid: no kill, immediate request at target.
    wait_req("rv_req");
    repeat (2) tick();
    Inst_jump_i = 1'b1;
    Src_jump_target_i = 32'h400;
    tick();
    Inst_jump_i = 1'b0;
    chk32("rv_req_now", {31'h0, Imem_req_o}, 32'h1);
    chk32("rv_addr", Imem_addr_o, 32'h400);

    // Redirect in HOLD under stall: buffer dropped, NOP forced, request at target.
    Stall_if = 1'b1;
    repeat (3) tick();
    Branch_taken_i = 1'b1;
    Src_branch_target_i = 32'h501;
    tick();
    Branch_taken_i = 1'b0;
    chk32("hold_redir_nop", Instruction_o, NOP);
    chk32("hold_redir_req", {31'h0, Imem_req_o}, 32'h1);
    chk32("hold_redir_addr", Imem_addr_o, 32'h500);
    Stall_if = 1'b0;
    wait_del("hold_redir_del");
    chk32("hold_redir_word", Instruction_o, 32'hC0DE_0500);

    // Reset while a request is outstanding; the late response lands in IDLE.
    wait_req("mid_rst_req");
    tick();
    Reset = 1'b1;
    mem_lat = 1;
    tick();
    Reset = 1'b0;
    wait_del("mid_rst_del");
    chk32("mid_rst_word", Instruction_o, 32'hC0DE_0000);
    chk32("mid_rst_pc", Src_pc_o, 32'h0);
    chk32("mid_rst_tag", {24'h0, IF_tracker_o}, TR ? 32'h1 : 32'h0);

    // 256 deliveries bring the tag back to zero.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    begin
      int n = 0;
      while (ndel < 256 && n < 700) begin
        tick();
        n++;
      end
      if (ndel < 256) timeout("tag_wrap");
      else chk32("tag_wrap", {24'h0, IF_tracker_o}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
